// File: rtl/avl_master_port.sv
// -----------------------------------------------------------------------------
// avl_master_port
//
// Avalon-MM initiator between the CPU core load/store request port and the
// shared memory bus. It accepts one byte, half or word access at a time and
// turns it into a word-aligned Avalon read or write with byteenable. While the
// slave asserts waitrequest, all bus outputs are held steady. Load data is
// lane-extracted and sign- or zero-extended before it is returned to the core.
//
// Ports
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   req_valid/req_ready   core request handshake (ready only in IDLE)
//   req_write             1 = store, 0 = load
//   req_size              00 byte, 01 half, 10 word, 11 illegal
//   req_signed            sign-extend byte/half loads
//   req_addr, req_wdata   byte address, right-justified store data
//   resp_valid            one-cycle completion pulse
//   resp_err              misaligned, illegal size or timeout
//   resp_rdata            extended load data (0 for stores and errors)
//   address, read, write, byteenable, writedata, readdata, waitrequest
//                         Avalon-MM master interface (read latency 0)
//   stall_count           saturating count of waitrequest-high bus cycles
// -----------------------------------------------------------------------------
module avl_master_port #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned STALL_CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    // core request
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [1:0]             req_size,
    input  logic                   req_signed,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_wdata,
    // core response
    output logic                   resp_valid,
    output logic                   resp_err,
    output logic [31:0]            resp_rdata,
    // Avalon-MM master
    output logic [31:0]            address,
    output logic                   read,
    output logic                   write,
    output logic [3:0]             byteenable,
    output logic [31:0]            writedata,
    input  logic [31:0]            readdata,
    input  logic                   waitrequest,
    // statistics
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // The wait counter only needs to reach TIMEOUT_CYCLES-1: the cycle that
    // would bring it to TIMEOUT_CYCLES is the one that triggers the timeout.
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic                   read_q, read_d;
    logic                   write_q, write_d;
    logic [31:0]            addr_q, addr_d;
    logic [3:0]             be_q, be_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   is_wr_q, is_wr_d;     // latched req_write
    logic [1:0]             size_q, size_d;
    logic                   sign_q, sign_d;
    logic [1:0]             lane_q, lane_d;
    logic                   resp_valid_q, resp_valid_d;
    logic                   resp_err_q, resp_err_d;
    logic [31:0]            resp_rdata_q, resp_rdata_d;
    logic [TO_W-1:0]        wait_cnt_q, wait_cnt_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    // -------------------------------------------------------------------------
    // Request decode: legality, byte lanes and replicated store data
    // -------------------------------------------------------------------------
    logic        req_legal;
    logic [3:0]  req_be;
    logic [31:0] req_wd;

    always_comb begin
        req_legal = 1'b0;
        req_be    = 4'b1111;
        req_wd    = req_wdata;
        case (req_size)
            SZ_BYTE: begin
                req_legal = 1'b1;
                req_be    = 4'b0001 << req_addr[1:0];
                req_wd    = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                req_legal = ~req_addr[0];
                req_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                req_wd    = {2{req_wdata[15:0]}};
            end
            SZ_WORD: begin
                req_legal = (req_addr[1:0] == 2'b00);
                req_be    = 4'b1111;
                req_wd    = req_wdata;
            end
            default: begin
                req_legal = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Load extraction from the live readdata (captured at the completing edge)
    // -------------------------------------------------------------------------
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        ld_byte = readdata[{lane_q, 3'b000} +: 8];
        ld_half = lane_q[1] ? readdata[31:16] : readdata[15:0];
        case (size_q)
            SZ_BYTE: ld_ext = {{24{sign_q & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_ext = {{16{sign_q & ld_half[15]}}, ld_half};
            default: ld_ext = readdata;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        read_d       = read_q;
        write_d      = write_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        is_wr_d      = is_wr_q;
        size_d       = size_q;
        sign_d       = sign_q;
        lane_d       = lane_q;
        wait_cnt_d   = wait_cnt_q;
        stall_d      = stall_q;
        // response registers are pulses: they fall back to 0 unless set below
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    is_wr_d = req_write;
                    size_d  = req_size;
                    sign_d  = req_signed;
                    lane_d  = req_addr[1:0];
                    if (req_legal) begin
                        state_d    = BUS;
                        read_d     = ~req_write;
                        write_d    = req_write;
                        addr_d     = {req_addr[31:2], 2'b00};
                        be_d       = req_be;
                        wdata_d    = req_wd;
                        wait_cnt_d = '0;
                    end else begin
                        // illegal request: report straight away, no bus cycle
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end
                end
            end

            BUS: begin
                if (waitrequest) begin
                    if (stall_q != '1) begin
                        stall_d = stall_q + STALL_CNT_W'(1);
                    end
                    if (wait_cnt_q == TO_LAST) begin
                        // slave never answered: abandon the transfer
                        state_d      = RESP;
                        read_d       = 1'b0;
                        write_d      = 1'b0;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + TO_W'(1);
                    end
                end else begin
                    state_d      = RESP;
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = is_wr_q ? 32'h0 : ld_ext;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            is_wr_q      <= 1'b0;
            size_q       <= '0;
            sign_q       <= 1'b0;
            lane_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            wait_cnt_q   <= '0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            read_q       <= read_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            is_wr_q      <= is_wr_d;
            size_q       <= size_d;
            sign_q       <= sign_d;
            lane_q       <= lane_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            wait_cnt_q   <= wait_cnt_d;
            stall_q      <= stall_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_err    = resp_err_q;
    assign resp_rdata  = resp_rdata_q;
    assign address     = addr_q;
    assign read        = read_q;
    assign write       = write_q;
    assign byteenable  = be_q;
    assign writedata   = wdata_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_avl_master_port.sv
module tb_avl_master_port;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata = '0;
    logic        waitrequest = 1'b0;
    logic [31:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    avl_master_port #(.TIMEOUT_CYCLES(8), .STALL_CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .address(address), .read(read), .write(write), .byteenable(byteenable),
        .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Reset for two cycles, release on a falling edge, return on the next one.
    task automatic do_reset();
        rst_n = 1'b0; req_valid = 1'b0; waitrequest = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called on a falling edge; the request is accepted on the next rising edge.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (read !== 1'b0) begin n_bad++; $display("FAIL rst_read: got %b want 0", read); end
        n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL rst_write: got %b want 0", write); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
        n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL rst_resp_err: got %b want 0", resp_err); end
        n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); end
        n_cmp++; if (address !== 32'h0) begin n_bad++; $display("FAIL rst_address: got %h want 0", address); end
        n_cmp++; if (byteenable !== 4'h0) begin n_bad++; $display("FAIL rst_be: got %b want 0", byteenable); end
        n_cmp++; if (writedata !== 32'h0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", writedata); end
        n_cmp++; if (stall_count !== 32'h0) begin n_bad++; $display("FAIL rst_stall: got %0d want 0", stall_count); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_word_read();
        do_reset();
        waitrequest = 1'b0; readdata = 32'h3C021234;
        issue(1'b0, 2'b10, 1'b0, 32'hBFC00004, 32'h0);
        @(negedge clk); // cycle 1: bus
        n_cmp++; if (read !== 1'b1) begin n_bad++; $display("FAIL wr_read: got %b want 1", read); end
        n_cmp++; if (address !== 32'hBFC00004) begin n_bad++; $display("FAIL wr_address: got %h want bfc00004", address); end
        n_cmp++; if (byteenable !== 4'b1111) begin n_bad++; $display("FAIL wr_be: got %b want 1111", byteenable); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL wr_early_resp: got %b want 0", resp_valid); end
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL wr_busy_ready: got %b want 0", req_ready); end
        @(negedge clk); // cycle 2: response
        n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL wr_resp_valid: got %b want 1", resp_valid); end
        n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL wr_resp_err: got %b want 0", resp_err); end
        n_cmp++; if (resp_rdata !== 32'h3C021234) begin n_bad++; $display("FAIL wr_rdata: got %h want 3c021234", resp_rdata); end
        n_cmp++; if (read !== 1'b0) begin n_bad++; $display("FAIL wr_read_drop: got %b want 0", read); end
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL wr_resp_pulse: got %b want 0", resp_valid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL wr_ready_back: got %b want 1", req_ready); end
    endtask

    task automatic test_byte_load_stall();
        do_reset();
        waitrequest = 1'b1; readdata = 32'h80FF7F01;
        issue(1'b0, 2'b00, 1'b1, 32'h00001003, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            n_cmp++; if (read !== 1'b1 || byteenable !== 4'b1000 || address !== 32'h00001000)
                begin n_bad++; $display("FAIL bl_hold_c%0d: got rd=%b be=%b a=%h want rd=1 be=1000 a=00001000", i, read, byteenable, address); end
            if (i == 4) waitrequest = 1'b0;
        end
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL bl_resp_valid: got %b want 1", resp_valid); end
        n_cmp++; if (resp_rdata !== 32'hFFFFFF80) begin n_bad++; $display("FAIL bl_rdata: got %h want ffffff80", resp_rdata); end
        n_cmp++; if (stall_count !== 32'd3) begin n_bad++; $display("FAIL bl_stall: got %0d want 3", stall_count); end
        n_cmp++; if (read !== 1'b0) begin n_bad++; $display("FAIL bl_read_drop: got %b want 0", read); end
    endtask

    task automatic test_load_ext();
        logic [1:0]  sz [4] = '{2'b01, 2'b01, 2'b00, 2'b01};
        logic        sg [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] ad [4] = '{32'h22, 32'h22, 32'h31, 32'h40};
        logic [3:0]  be [4] = '{4'b1100, 4'b1100, 4'b0010, 4'b0011};
        logic [31:0] ex [4] = '{32'hFFFF80FF, 32'h000080FF, 32'h0000007F, 32'h00007F01};
        do_reset();
        waitrequest = 1'b0; readdata = 32'h80FF7F01;
        for (int k = 0; k < 4; k++) begin
            issue(1'b0, sz[k], sg[k], ad[k], 32'h0);
            @(negedge clk);
            n_cmp++; if (byteenable !== be[k]) begin n_bad++; $display("FAIL ld%0d_be: got %b want %b", k, byteenable, be[k]); end
            @(negedge clk);
            n_cmp++; if (resp_valid !== 1'b1 || resp_rdata !== ex[k])
                begin n_bad++; $display("FAIL ld%0d_rdata: got v=%b %h want v=1 %h", k, resp_valid, resp_rdata, ex[k]); end
            @(negedge clk);
        end
    endtask

    task automatic test_half_store();
        do_reset();
        waitrequest = 1'b0;
        issue(1'b1, 2'b01, 1'b0, 32'h00000002, 32'h0000ABCD);
        @(negedge clk);
        n_cmp++; if (write !== 1'b1 || read !== 1'b0) begin n_bad++; $display("FAIL hs_strobe: got wr=%b rd=%b want wr=1 rd=0", write, read); end
        n_cmp++; if (byteenable !== 4'b1100) begin n_bad++; $display("FAIL hs_be: got %b want 1100", byteenable); end
        n_cmp++; if (writedata !== 32'hABCDABCD) begin n_bad++; $display("FAIL hs_wdata: got %h want abcdabcd", writedata); end
        n_cmp++; if (address !== 32'h0) begin n_bad++; $display("FAIL hs_address: got %h want 0", address); end
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0)
            begin n_bad++; $display("FAIL hs_resp: got v=%b e=%b d=%h want v=1 e=0 d=0", resp_valid, resp_err, resp_rdata); end
        n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL hs_write_drop: got %b want 0", write); end
        @(negedge clk);
        // byte store on lane 1
        issue(1'b1, 2'b00, 1'b0, 32'h00000101, 32'h1234565A);
        @(negedge clk);
        n_cmp++; if (byteenable !== 4'b0010 || writedata !== 32'h5A5A5A5A || address !== 32'h100)
            begin n_bad++; $display("FAIL bs_lanes: got be=%b d=%h a=%h want be=0010 d=5a5a5a5a a=00000100", byteenable, writedata, address); end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        logic [1:0]  sz [2] = '{2'b10, 2'b11};
        logic [31:0] ad [2] = '{32'h6, 32'h0};
        do_reset();
        for (int k = 0; k < 2; k++) begin
            issue(1'b0, sz[k], 1'b0, ad[k], 32'h0);
            @(negedge clk);
            n_cmp++; if (read !== 1'b0 || write !== 1'b0) begin n_bad++; $display("FAIL il%0d_nobus: got rd=%b wr=%b want 0 0", k, read, write); end
            n_cmp++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0)
                begin n_bad++; $display("FAIL il%0d_resp: got v=%b e=%b d=%h want v=1 e=1 d=0", k, resp_valid, resp_err, resp_rdata); end
            @(negedge clk);
            n_cmp++; if (req_ready !== 1'b1 || resp_valid !== 1'b0)
                begin n_bad++; $display("FAIL il%0d_ready: got rdy=%b v=%b want rdy=1 v=0", k, req_ready, resp_valid); end
        end
    endtask

    task automatic test_timeout();
        int highs = 0;
        do_reset();
        waitrequest = 1'b1;
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (read === 1'b1) highs++;
        end
        n_cmp++; if (highs !== 8) begin n_bad++; $display("FAIL to_read_cycles: got %0d want 8", highs); end
        @(negedge clk);
        n_cmp++; if (read !== 1'b0) begin n_bad++; $display("FAIL to_read_drop: got %b want 0", read); end
        n_cmp++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0)
            begin n_bad++; $display("FAIL to_resp: got v=%b e=%b d=%h want v=1 e=1 d=0", resp_valid, resp_err, resp_rdata); end
        n_cmp++; if (stall_count !== 32'd8) begin n_bad++; $display("FAIL to_stall: got %0d want 8", stall_count); end
        waitrequest = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL to_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_reset_mid_bus();
        int seen = 0;
        do_reset();
        waitrequest = 1'b1;
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        repeat (2) @(negedge clk);
        n_cmp++; if (write !== 1'b1) begin n_bad++; $display("FAIL rm_write_before: got %b want 1", write); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL rm_write_async: got %b want 0", write); end
        n_cmp++; if (stall_count !== 32'd0) begin n_bad++; $display("FAIL rm_stall: got %0d want 0", stall_count); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen++;
        end
        rst_n = 1'b1; waitrequest = 1'b0; readdata = 32'h12345678;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rm_no_resp: got %0d pulses want 0", seen); end
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        n_cmp++; if (read !== 1'b1 || address !== 32'h20) begin n_bad++; $display("FAIL rm_next_read: got rd=%b a=%h want rd=1 a=00000020", read, address); end
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h12345678)
            begin n_bad++; $display("FAIL rm_next_resp: got v=%b d=%h want v=1 d=12345678", resp_valid, resp_rdata); end
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_byte_load_stall();
        test_load_ext();
        test_half_store();
        test_illegal();
        test_timeout();
        test_reset_mid_bus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/avl_master_port.md
Name: avl_master_port

Overview:
- Avalon-MM initiator that connects the CPU core's load/store request port to the shared memory bus.
- Turns byte, half and word accesses into word-aligned Avalon reads and writes with byteenable.
- Holds the bus stable while `waitrequest` is high, then returns lane-extracted read data to the core.
- Sits inside `mips_cpu_bus` and is used for both instruction and data accesses. One transaction is outstanding at a time.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum consecutive `waitrequest`-high cycles before the transaction is abandoned with an error. Must be ≥2.
- STALL_CNT_W, 32: width of the saturating stall counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  core request present.
- req_ready  output  1  port can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal.
- req_signed  input  1  sign-extend load result (byte/half only).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  one-cycle completion pulse.
- resp_err  output  1  qualifies `resp_valid`: misaligned, illegal size, or timeout.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- address  output  32  Avalon word address (`req_addr` with bits [1:0] forced to 0).
- read  output  1  Avalon read.
- write  output  1  Avalon write.
- byteenable  output  4  Avalon byte lanes.
- writedata  output  32  lane-shifted store data.
- readdata  input  32  Avalon read data.
- waitrequest  input  1  Avalon slave stall.
- stall_count  output  STALL_CNT_W  saturating count of `waitrequest`-high cycles during bus transactions.

Behaviour:
- Reset (async, `rst_n`=0): all of the following are 0 — `read`, `write`, `resp_valid`, `resp_err`, `resp_rdata`, `address`, `byteenable`, `writedata`, `stall_count`. State is IDLE. `req_ready` is 1 once `rst_n` deasserts.
- FSM states: IDLE, BUS, RESP. `req_ready` = (state==IDLE).
- IDLE, accept: on `req_valid` && `req_ready`, latch the request.
  - Legal (size≠11, address aligned to size) → BUS. Next cycle drive `address`, `byteenable`, `writedata`, and `read`/`write`.
  - Illegal → RESP with error; no bus cycle.
- Byte lanes (`a` = `req_addr[1:0]`):
  - Byte: `byteenable` = 1<<a; `writedata` = `{4{wdata[7:0]}}`.
  - Half: `byteenable` = 0011 (a=0) or 1100 (a=2); `writedata` = `{2{wdata[15:0]}}`.
  - Word: `byteenable` = 1111; `writedata` = `wdata`.
- BUS state:
  - All Avalon outputs stay constant while `waitrequest`=1; `stall_count` increments per such cycle, saturating at all-ones.
  - On a rising edge with `waitrequest`=0: transaction complete. For a read, capture `readdata` at that edge (read latency 0). Deassert `read`/`write` the next cycle; go to RESP.
  - A slave holding `waitrequest` low on the first cycle gives a 1-cycle bus transaction.
- Timeout: if `waitrequest` stays 1 for TIMEOUT_CYCLES consecutive BUS cycles, drop `read`/`write` → RESP with `resp_err`=1.
- RESP state: `resp_valid`=1 for exactly one cycle, then IDLE. `req_ready` rises in the cycle after `resp_valid`.
  - Minimum accept-to-`resp_valid` latency: 2 cycles.
- Load extraction: select the byte/half by `a` from the captured word; sign- or zero-extend per `req_signed`. Word loads pass through.
- `req_*` inputs are ignored outside IDLE; there is no back-to-back accept while busy.
- `rst_n` asserted mid-BUS: `read`/`write` drop immediately (async); no response is issued for the aborted request.

Test Plan:
- Word read, slave `waitrequest`=0, `req_addr`=0xBFC00004, `readdata`=0x3C021234 → `address`=0xBFC00004, `byteenable`=1111; `resp_rdata`=0x3C021234, `resp_err`=0, 2 cycles accept-to-`resp_valid`.
- Signed byte load at 0x00001003, `readdata`=0x80FF7F01, slave stalls 3 cycles → `byteenable`=1000, `read` held stable 4 cycles, `resp_rdata`=0xFFFFFF80, `stall_count`=3.
- Half store 0x0000ABCD at 0x00000002 → `write`=1, `byteenable`=1100, `writedata`=0xABCDABCD; `resp_valid` with `resp_rdata`=0.
- Misaligned word load at 0x00000006 → no `read`/`write` asserted, `resp_valid`=1, `resp_err`=1, next cycle `req_ready`=1.
- `waitrequest` stuck at 1 with TIMEOUT_CYCLES=8 → `read` high exactly 8 cycles, then `resp_err`=1; `stall_count`=8.
- `rst_n` pulsed low during a stalled write → `write`=0 immediately, no `resp_valid`, `stall_count`=0; a subsequent word read completes normally.
